// File: rtl/serial_parity_unit.sv
// Serial parity stage: shifts in FRAME_LEN bits MSB first and emits the frame with its XOR/XNOR.
// Define SERIAL_PARITY_CHECK_EN to take a trailing received parity bit per frame and flag mismatches on err.
module serial_parity_unit #(
  parameter int FRAME_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic [FRAME_LEN-1:0] frame_out,
  output logic                 xor_out,
  output logic                 xnor_out,
  output logic                 done,
  output logic                 err
);
  localparam int CW = $clog2(FRAME_LEN + 1);

`ifdef SERIAL_PARITY_CHECK_EN
  typedef enum logic {ACC = 1'b0, CHK = 1'b1} state_t;
`else
  typedef enum logic {ACC = 1'b0} state_t;
`endif

  state_t               r_state, w_nstate;
  logic [CW-1:0]        r_cnt;
  logic [FRAME_LEN-1:0] r_shift;
  logic                 r_par;
  logic [FRAME_LEN-1:0] r_frame;
  logic                 r_xor;
  logic                 r_done;
  logic [FRAME_LEN-1:0] w_shift_nxt;
  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_xor;
  logic                 w_emit;
  logic                 w_last;

  assign w_shift_nxt = {r_shift[FRAME_LEN-2:0], bit_in};
  assign w_last      = (r_cnt == CW'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_emit   = 1'b0;
    w_frame  = w_shift_nxt;
    w_xor    = r_par ^ bit_in;
    if (clr) begin
      w_nstate = ACC;
    end else if (bit_valid) begin
      case (r_state)
        ACC: begin
          if (w_last) begin
`ifdef SERIAL_PARITY_CHECK_EN
            w_nstate = CHK;
`else
            w_emit   = 1'b1;
`endif
          end
        end
`ifdef SERIAL_PARITY_CHECK_EN
        // Frame and data parity already sit in r_shift/r_par; this bit is the received parity.
        CHK: begin
          w_emit   = 1'b1;
          w_frame  = r_shift;
          w_xor    = r_par;
          w_nstate = ACC;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_frame <= '0;
      r_xor   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_emit;
      if (clr) begin
        r_cnt   <= '0;
        r_shift <= '0;
        r_par   <= 1'b0;
      end else if (w_emit) begin
        r_cnt   <= '0;
        r_par   <= 1'b0;
        r_frame <= w_frame;
        r_xor   <= w_xor;
      end else if (bit_valid) begin
        r_shift <= w_shift_nxt;
        r_par   <= r_par ^ bit_in;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_PARITY_CHECK_EN
  logic r_err;
  // Even parity over data plus received bit: nonzero means mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_err <= 1'b0;
    else if (w_emit) r_err <= r_par ^ bit_in;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign frame_out = r_frame;
  assign xor_out   = r_xor;
  assign xnor_out  = ~r_xor;
  assign done      = r_done;
endmodule

// File: doc/serial_parity_unit.md
# serial_parity_unit

Serial XOR/XNOR parity stage that sits directly upstream of the combinational exclusive gate logic. It accumulates a serial bitstream one bit per accepted clock, assembles fixed-length frames, and emits the frame word with its XOR (odd) and XNOR (even) reduction plus a one-cycle `done` strobe. An optional check mode takes one trailing received parity bit per frame and flags mismatches.

## Interface
- `FRAME_LEN`, 8: data bits per frame. Legal range is 2..32.
- `clk`  input  1  Rising-edge clock. This is the only clock.
- `rst_n`  input  1  Asynchronous, active-low reset.
- `clr`  input  1  Synchronous frame abort. Takes priority over `bit_valid`.
- `bit_valid`  input  1  `bit_in` is accepted on the rising edge while this is high.
- `bit_in`  input  1  Serial data bit, MSB first.
- `frame_out`  output  FRAME_LEN  Last completed frame. The first received bit is at the MSB.
- `xor_out`  output  1  XOR of all data bits of the last frame.
- `xnor_out`  output  1  Always equal to `~xor_out`.
- `done`  output  1  One-cycle strobe marking that the outputs have just updated.
- `err`  output  1  Parity mismatch on the last frame. Tied to 0 when check mode is not compiled in.

## Operation
- Internal state:
  - bit counter, `$clog2(FRAME_LEN+1)` bits wide;
  - shift register, FRAME_LEN bits;
  - running parity, 1 bit;
  - FSM with states ACC and CHK (CHK exists only when check mode is compiled in).
- **ACC, accepting a bit:**
  - shift register becomes `{shift[FRAME_LEN-2:0], bit_in}`;
  - running parity becomes `parity ^ bit_in`;
  - counter increments.
- **ACC, accepting the FRAME_LEN-th bit (check mode off):**
  - `frame_out`, `xor_out`, `xnor_out` load the final values, including that bit;
  - `done` is set to 1;
  - counter and running parity clear to 0, state stays ACC.
- **ACC, accepting the FRAME_LEN-th bit (check mode on):**
  - the frame word and parity are held internally;
  - state moves to CHK and no `done` is raised.
- **CHK, accepting a bit:** that bit is the received parity bit `p`.
  - Outputs load the frame and data parity.
  - `err` loads `data_xor ^ p`, i.e. even parity over data plus `p`.
  - `done` is set to 1 and state returns to ACC with counter and parity cleared.
- Cycles with `bit_valid` low are idle cycles. State and counters hold, and gaps of any length are allowed.
- **`clr` high:**
  - counter, running parity and shift register clear, and state returns to ACC;
  - `done` is 0 on the next cycle;
  - `frame_out`, `xor_out`, `xnor_out` and `err` keep their last values;
  - the bit on `bit_in` in that cycle is discarded.
- Outputs change only on a `done` update, `clr` (for `done` only), or reset.

## Timing
- Reset values:
  - `frame_out` = 0, `xor_out` = 0, `xnor_out` = 1, `done` = 0, `err` = 0;
  - counter = 0, parity = 0, state ACC.
- Reset is asynchronous and takes effect mid-frame. A partial frame is dropped, with no `done` and no output change other than the reset values.
- Latency: outputs and `done` are valid in the cycle after the edge that accepts the last bit of a frame. That last bit is the FRAME_LEN-th data bit, or the parity bit in check mode.
- `done` is high for exactly one cycle, even when `bit_valid` stays high.
- Back-to-back frames:
  - the first bit of the next frame is accepted in the same cycle that `done` is high;
  - no bubble is required;
  - throughput is one frame per FRAME_LEN accepted bits (FRAME_LEN+1 in check mode).
- No backpressure: every bit presented with `bit_valid` high is always accepted.

## Configuration
- Macro: `SERIAL_PARITY_CHECK_EN`.
- **Defined:**
  - the CHK state is present;
  - each frame is FRAME_LEN data bits plus 1 parity bit;
  - `err` is driven as specified above.
- **Undefined:**
  - there is no CHK state and frames are FRAME_LEN bits;
  - `err` is a constant 0 and resets to 0.

## Test plan
All scenarios use FRAME_LEN=8.
- **Even-weight frame:**
  - Stimulus: bits 1,0,1,1,0,0,1,0 (4 ones) with `bit_valid` held high.
  - Required: one cycle after the 8th edge, `done`=1 for one cycle, `frame_out`=8'hB2, `xor_out`=0, `xnor_out`=1.
- **Odd weight with gaps:**
  - Stimulus: bits of 8'hB3 with `bit_valid` low for 3 cycles between bits 4 and 5.
  - Required: `frame_out`=8'hB3, `xor_out`=1, `xnor_out`=0, and exactly one `done` pulse.
- **Back-to-back frames:**
  - Stimulus: 8'hB2 then 8'hFF with no gap.
  - Required: two `done` pulses 8 cycles apart, the second with `frame_out`=8'hFF and `xor_out`=0.
- **Abort and reset:**
  - Stimulus: `clr` after 5 bits, then a full 8'h01 frame.
  - Required: `done` only after the full 8'h01 frame, with `xor_out`=1.
  - Stimulus: assert `rst_n` low after 3 bits.
  - Required: all outputs return to their reset values immediately.
- **Check mode** (`SERIAL_PARITY_CHECK_EN` defined):
  - Stimulus: 8'hB2 followed by parity bit 0. Required: `err`=0 and `done` on the 9th accepted bit.
  - Stimulus: 8'hB2 followed by parity bit 1. Required: `err`=1.
  - Stimulus: 8'hB3 followed by parity bit 1. Required: `err`=0.
